ay_register_file: RTL and testbench

Bus-side register file for the AY-3-8913 core: decodes the BDIR/BC1 bus protocol, holds the sixteen programmable registers R0–R15, and drives the period, mixer, amplitude and envelope-shape fields into the tone, noise, mixer and envelope stages. It sits directly upstream of the envelope generator. It supplies that stage's `period`, `hold`, `alternate`, `attack` and `continue_` inputs, plus a one-cycle restart pulse on every shape-register write.

---
 rtl/ay_register_file.sv | 151 +++++++++++++++
 tb/tb_ay_register_file.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ay_register_file.sv
// AY-3-8913 bus-side register file.
// BDIR/BC1 decode, R0-R15 storage and field fan-out to tone/noise/mixer/envelope.
module ay_register_file #(
    parameter logic [3:0] CHIP_ADDR_HI = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bdir,
    input  logic        bc1,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  io_a_in,
    input  logic [7:0]  io_b_in,
    output logic [7:0]  io_a_out,
    output logic [7:0]  io_b_out,
    output logic [11:0] tone_period_a,
    output logic [11:0] tone_period_b,
    output logic [11:0] tone_period_c,
    output logic [4:0]  noise_period,
    output logic [7:0]  mixer,
    output logic [3:0]  amp_a,
    output logic [3:0]  amp_b,
    output logic [3:0]  amp_c,
    output logic        amp_env_a,
    output logic        amp_env_b,
    output logic        amp_env_c,
    output logic [15:0] env_period,
    output logic        env_continue,
    output logic        env_attack,
    output logic        env_alternate,
    output logic        env_hold,
    output logic        env_restart
);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_LATCH = 2'b11
    } bus_mode_t;

    localparam logic [3:0] ADDR_ENV_SHAPE = 4'd13;
    localparam logic [3:0] ADDR_IO_A      = 4'd14;
    localparam logic [3:0] ADDR_IO_B      = 4'd15;
    localparam logic [3:0] ADDR_MIXER     = 4'd7;

    bus_mode_t  mode;
    logic [3:0] addr;
    logic       selected;
    logic       write_seen;
    logic       write_fire;
    logic [7:0] regs [16];
    logic [7:0] rd_value;

    // Bits each register actually implements; the rest are dropped on write.
    function automatic logic [7:0] impl_mask(input logic [3:0] a);
        logic [7:0] m;
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: m = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: m = 8'h1F;
            default:                 m = 8'hFF;
        endcase
        return m;
    endfunction

    assign mode = bus_mode_t'({bdir, bc1});

    // Only the first cycle of a contiguous write phase stores data.
    assign write_fire = (mode == MODE_WRITE) && !write_seen && selected;

    // Address latch, chip select and write-phase edge tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= 4'd0;
            selected   <= 1'b1;
            write_seen <= 1'b0;
        end else begin
            write_seen <= (mode == MODE_WRITE);
            if (mode == MODE_LATCH) begin
                addr     <= data_in[3:0];
                selected <= (data_in[7:4] == CHIP_ADDR_HI);
            end
        end
    end

    // Register storage with per-register bit masking.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (write_fire) begin
            regs[addr] <= data_in & impl_mask(addr);
        end
    end

    // Read source: I/O registers return the pins while in input direction.
    always_comb begin
        rd_value = regs[addr];
        if (addr == ADDR_IO_A && !regs[ADDR_MIXER][6]) begin
            rd_value = io_a_in;
        end
        if (addr == ADDR_IO_B && !regs[ADDR_MIXER][7]) begin
            rd_value = io_b_in;
        end
    end

    // Registered read data, refreshed every cycle of a selected read.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= 8'h00;
            data_oe  <= 1'b0;
        end else if (mode == MODE_READ && selected) begin
            data_out <= rd_value;
            data_oe  <= 1'b1;
        end else begin
            data_out <= 8'h00;
            data_oe  <= 1'b0;
        end
    end

    // One-cycle envelope restart, coincident with the new shape bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            env_restart <= 1'b0;
        end else begin
            env_restart <= write_fire && (addr == ADDR_ENV_SHAPE);
        end
    end

    assign tone_period_a = {regs[1][3:0], regs[0]};
    assign tone_period_b = {regs[3][3:0], regs[2]};
    assign tone_period_c = {regs[5][3:0], regs[4]};
    assign noise_period  = regs[6][4:0];
    assign mixer         = regs[ADDR_MIXER];
    assign amp_a         = regs[8][3:0];
    assign amp_b         = regs[9][3:0];
    assign amp_c         = regs[10][3:0];
    assign amp_env_a     = regs[8][4];
    assign amp_env_b     = regs[9][4];
    assign amp_env_c     = regs[10][4];
    assign env_period    = {regs[12], regs[11]};
    assign env_continue  = regs[ADDR_ENV_SHAPE][3];
    assign env_attack    = regs[ADDR_ENV_SHAPE][2];
    assign env_alternate = regs[ADDR_ENV_SHAPE][1];
    assign env_hold      = regs[ADDR_ENV_SHAPE][0];
    assign io_a_out      = regs[ADDR_IO_A];
    assign io_b_out      = regs[ADDR_IO_B];

endmodule

// File: tb/tb_ay_register_file.sv
// Directed bench for ay_register_file.
// Expected values queue up with the stimulus and are compared after each edge.
module tb_ay_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        bdir;
    logic        bc1;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  io_a_in;
    logic [7:0]  io_b_in;
    logic [7:0]  io_a_out;
    logic [7:0]  io_b_out;
    logic [11:0] tone_period_a;
    logic [11:0] tone_period_b;
    logic [11:0] tone_period_c;
    logic [4:0]  noise_period;
    logic [7:0]  mixer;
    logic [3:0]  amp_a;
    logic [3:0]  amp_b;
    logic [3:0]  amp_c;
    logic        amp_env_a;
    logic        amp_env_b;
    logic        amp_env_c;
    logic [15:0] env_period;
    logic        env_continue;
    logic        env_attack;
    logic        env_alternate;
    logic        env_hold;
    logic        env_restart;

    int passed = 0;
    int total  = 0;

    string       sb_tag [$];
    logic [31:0] sb_exp [$];

    ay_register_file #(.CHIP_ADDR_HI(4'b0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .bdir          (bdir),
        .bc1           (bc1),
        .data_in       (data_in),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .io_a_in       (io_a_in),
        .io_b_in       (io_b_in),
        .io_a_out      (io_a_out),
        .io_b_out      (io_b_out),
        .tone_period_a (tone_period_a),
        .tone_period_b (tone_period_b),
        .tone_period_c (tone_period_c),
        .noise_period  (noise_period),
        .mixer         (mixer),
        .amp_a         (amp_a),
        .amp_b         (amp_b),
        .amp_c         (amp_c),
        .amp_env_a     (amp_env_a),
        .amp_env_b     (amp_env_b),
        .amp_env_c     (amp_env_c),
        .env_period    (env_period),
        .env_continue  (env_continue),
        .env_attack    (env_attack),
        .env_alternate (env_alternate),
        .env_hold      (env_hold),
        .env_restart   (env_restart)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [31:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (sb_exp.size() == 0) begin
            $display("FAIL sb_empty: observed %0h expected queued value", obs);
            return;
        end
        t = sb_tag.pop_front();
        e = sb_exp.pop_front();
        assert (obs === e) passed = passed + 1;
        else begin
            $display("FAIL %s: observed %0h expected %0h", t, obs, e);
            $error("%s observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [7:0] d);
        {bdir, bc1} = m;
        data_in = d;
        tick();
    endtask

    task automatic idle();
        drive(2'b00, 8'h00);
    endtask

    task automatic latch(input logic [7:0] a);
        drive(2'b11, a);
    endtask

    initial begin
        reset = 1'b1;
        {bdir, bc1} = 2'b00;
        data_in = 8'h00;
        io_a_in = 8'h3C;
        io_b_in = 8'h00;
        tick();
        tick();

        push("rst_tone_a", 32'h000);
        push("rst_env_period", 32'h0000);
        push("rst_mixer", 32'h00);
        push("rst_data_oe", 32'h0);
        push("rst_env_restart", 32'h0);
        push("rst_noise", 32'h00);
        reset = 1'b0;
        tick();
        check(32'(tone_period_a));
        check(32'(env_period));
        check(32'(mixer));
        check(32'(data_oe));
        check(32'(env_restart));
        check(32'(noise_period));

        push("rst_addr_write", 32'h012);
        drive(2'b10, 8'h12);
        check(32'(tone_period_a));
        idle();

        latch(8'h01);
        drive(2'b10, 8'hFF);
        idle();
        latch(8'h00);
        push("tone_mask", 32'hFA5);
        drive(2'b10, 8'hA5);
        check(32'(tone_period_a));
        idle();
        latch(8'h01);
        push("read_r1_data", 32'h0F);
        push("read_r1_oe", 32'h1);
        drive(2'b01, 8'h00);
        check(32'(data_out));
        check(32'(data_oe));
        push("idle_data", 32'h00);
        push("idle_oe", 32'h0);
        idle();
        check(32'(data_out));
        check(32'(data_oe));

        latch(8'h0D);
        push("env_shape", 32'hE);
        push("env_restart_pulse", 32'h1);
        drive(2'b10, 8'h0E);
        check(32'({env_continue, env_attack, env_alternate, env_hold}));
        check(32'(env_restart));
        push("env_restart_end", 32'h0);
        drive(2'b10, 8'h0E);
        check(32'(env_restart));
        push("env_restart_hold", 32'h0);
        drive(2'b10, 8'h0E);
        check(32'(env_restart));
        idle();
        push("env_same_restart", 32'h1);
        drive(2'b10, 8'h0E);
        check(32'(env_restart));
        idle();

        latch(8'h3B);
        push("unsel_write", 32'h0000);
        drive(2'b10, 8'h55);
        check(32'(env_period));
        idle();
        push("unsel_read_oe", 32'h0);
        push("unsel_read_data", 32'h00);
        drive(2'b01, 8'h00);
        check(32'(data_oe));
        check(32'(data_out));
        idle();
        latch(8'h0B);
        push("sel_write", 32'h0055);
        push("r11_no_restart", 32'h0);
        drive(2'b10, 8'h55);
        check(32'(env_period));
        check(32'(env_restart));
        idle();

        latch(8'h0E);
        push("io_a_out", 32'hC3);
        drive(2'b10, 8'hC3);
        check(32'(io_a_out));
        idle();
        push("io_a_pins", 32'h3C);
        drive(2'b01, 8'h00);
        check(32'(data_out));
        io_a_in = 8'h5A;
        push("io_a_track", 32'h5A);
        drive(2'b01, 8'h00);
        check(32'(data_out));
        idle();
        latch(8'h07);
        push("mixer_wr", 32'h40);
        drive(2'b10, 8'h40);
        check(32'(mixer));
        idle();
        latch(8'h0E);
        push("io_a_stored", 32'hC3);
        drive(2'b01, 8'h00);
        check(32'(data_out));
        idle();

        latch(8'h06);
        push("noise_ff", 32'h1F);
        drive(2'b10, 8'hFF);
        check(32'(noise_period));
        idle();
        push("noise_21", 32'h01);
        drive(2'b10, 8'h21);
        check(32'(noise_period));
        drive(2'b11, 8'h06);
        push("noise_after_latch", 32'h0A);
        drive(2'b10, 8'h0A);
        check(32'(noise_period));
        drive(2'b01, 8'h00);
        push("noise_after_read", 32'h07);
        drive(2'b10, 8'h07);
        check(32'(noise_period));
        push("noise_held_ignored", 32'h07);
        drive(2'b10, 8'h1F);
        check(32'(noise_period));
        idle();

        push("rst_mid_noise", 32'h00);
        push("rst_mid_tone", 32'h000);
        reset = 1'b1;
        drive(2'b10, 8'h15);
        check(32'(noise_period));
        check(32'(tone_period_a));
        reset = 1'b0;
        push("post_rst_write", 32'h015);
        drive(2'b10, 8'h15);
        check(32'(tone_period_a));
        idle();

        total++;
        assert (sb_exp.size() == 0) passed = passed + 1;
        else begin
            $display("FAIL sb_drain: observed %0d expected 0", sb_exp.size());
            $error("scoreboard not drained");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
